// File: rtl/uart_pkg.sv
// ============================================================================
// Module  : uart_pkg
// Brief   : Shared state encodings, status bit positions and flow-control margin.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package uart_pkg;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE      = 3'd0,
        RX_START     = 3'd1,
        RX_DATA      = 3'd2,
        RX_STOP      = 3'd3,
        RX_WAIT_HIGH = 3'd4
    } rx_state_t;

    localparam int c_STAT_TX_FULL   = 0;
    localparam int c_STAT_TX_EMPTY  = 1;
    localparam int c_STAT_RX_FULL   = 2;
    localparam int c_STAT_RX_EMPTY  = 3;
    localparam int c_STAT_OVERRUN   = 4;
    localparam int c_STAT_FRAME_ERR = 5;
    localparam int c_STAT_TX_BUSY   = 6;
    localparam int c_STAT_LEVEL_LSB = 8;

    localparam int RTS_MARGIN = 4;

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// ============================================================================
// Module  : sync_fifo
// Brief   : First-word-fall-through FIFO with full/empty flags and fill level.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module sync_fifo #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_pop,
    output logic [DATA_W-1:0] o_data,
    output logic              o_full,
    output logic              o_empty,
    output logic [ADDR_W:0]   o_level
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [ADDR_W:0]   r_wr_ptr;
    logic [ADDR_W:0]   r_rd_ptr;
    logic [ADDR_W:0]   w_level;
    logic              w_do_push;
    logic              w_do_pop;

    // Level never exceeds DEPTH, so its MSB alone marks full.
    assign w_level   = r_wr_ptr - r_rd_ptr;
    assign o_level   = w_level;
    assign o_full    = w_level[ADDR_W];
    assign o_empty   = (w_level == '0);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_data    = r_mem[r_rd_ptr[ADDR_W-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[ADDR_W-1:0]] <= i_data;
    end

endmodule

`default_nettype wire

// File: rtl/uart_fifo_bridge.sv
// ============================================================================
// Module  : uart_fifo_bridge
// Brief   : TX FIFO + serializer and RX deserializer + FIFO for the CPU bus.
//           Optional RTS/CTS flow control enabled by UART_FLOW_CTRL_EN.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module uart_fifo_bridge
    import uart_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int ADDR_W       = 4,
    parameter int CLKS_PER_BIT = 104
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [DATA_W-1:0] dataIn,
    input  logic              write,
    input  logic              read,
    input  logic              clearErr,
    output logic [DATA_W-1:0] dataOut,
    output logic [15:0]       status,
`ifdef UART_FLOW_CTRL_EN
    input  logic              CTS_n,
    output logic              RTS_n,
`endif
    input  logic              RX,
    output logic              TX
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_W);

    tx_state_t         r_tx_state, w_tx_next;
    rx_state_t         r_rx_state, w_rx_next;
    logic [CNT_W-1:0]  r_tx_cnt, r_rx_cnt;
    logic [IDX_W-1:0]  r_tx_idx, r_rx_idx;
    logic [DATA_W-1:0] r_tx_shift, r_rx_shift;
    logic              r_tx, r_rx_meta, r_rx_sync, r_rx_push, r_overrun, r_frame_err;
    logic              w_tx_pop, w_tx_tick, w_rx_half, w_rx_tick, w_rx_cnt_clr;
    logic              w_rx_done, w_frame_err, w_cts_ok;
    logic              w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
    logic [DATA_W-1:0] w_tx_head, w_rx_head;
    logic [ADDR_W:0]   w_rx_level, w_tx_level_unused;

    sync_fifo #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_tx_fifo (
        .clk(CLK), .rst(RST), .i_push(write), .i_data(dataIn), .i_pop(w_tx_pop),
        .o_data(w_tx_head), .o_full(w_tx_full), .o_empty(w_tx_empty), .o_level(w_tx_level_unused)
    );

    sync_fifo #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rx_fifo (
        .clk(CLK), .rst(RST), .i_push(r_rx_push), .i_data(r_rx_shift), .i_pop(read),
        .o_data(w_rx_head), .o_full(w_rx_full), .o_empty(w_rx_empty), .o_level(w_rx_level)
    );

`ifdef UART_FLOW_CTRL_EN
    localparam int RTS_TH = (2**ADDR_W > RTS_MARGIN) ? (2**ADDR_W - RTS_MARGIN) : 0;
    logic r_cts_meta, r_cts_sync, r_rts_n;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_cts_meta <= 1'b1;
            r_cts_sync <= 1'b1;
            r_rts_n    <= 1'b0;
        end else begin
            r_cts_meta <= CTS_n;
            r_cts_sync <= r_cts_meta;
            r_rts_n    <= (int'(w_rx_level) >= RTS_TH);
        end
    end
    assign w_cts_ok = !r_cts_sync;
    assign RTS_n    = r_rts_n;
`else
    assign w_cts_ok = 1'b1;
`endif

    always_comb begin
        w_tx_next = r_tx_state;
        w_tx_pop  = 1'b0;
        w_tx_tick = (r_tx_cnt == CNT_W'(CLKS_PER_BIT - 1));
        case (r_tx_state)
            TX_IDLE:  if (!w_tx_empty && w_cts_ok) begin
                          w_tx_pop  = 1'b1;
                          w_tx_next = TX_START;
                      end
            TX_START: if (w_tx_tick) w_tx_next = TX_DATA;
            TX_DATA:  if (w_tx_tick && r_tx_idx == IDX_W'(DATA_W - 1)) w_tx_next = TX_STOP;
            TX_STOP:  if (w_tx_tick) w_tx_next = TX_IDLE;
            default:  w_tx_next = TX_IDLE;
        endcase
    end

    // TX pin is re-registered from the current state, so the start bit
    // appears one edge after the IDLE pop.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_tx_state <= TX_IDLE;
            r_tx_cnt   <= '0;
            r_tx_idx   <= '0;
            r_tx_shift <= '0;
            r_tx       <= 1'b1;
        end else begin
            r_tx_state <= w_tx_next;
            r_tx_cnt   <= (r_tx_state == TX_IDLE || w_tx_tick) ? '0 : r_tx_cnt + 1'b1;
            if (w_tx_pop) begin
                r_tx_shift <= w_tx_head;
                r_tx_idx   <= '0;
            end else if (r_tx_state == TX_DATA && w_tx_tick) begin
                r_tx_shift <= r_tx_shift >> 1;
                r_tx_idx   <= r_tx_idx + 1'b1;
            end
            case (r_tx_state)
                TX_START: r_tx <= 1'b0;
                TX_DATA:  r_tx <= r_tx_shift[0];
                default:  r_tx <= 1'b1;
            endcase
        end
    end

    always_comb begin
        w_rx_next    = r_rx_state;
        w_rx_half    = (r_rx_cnt == CNT_W'(CLKS_PER_BIT / 2 - 1));
        w_rx_tick    = (r_rx_cnt == CNT_W'(CLKS_PER_BIT - 1));
        w_rx_cnt_clr = 1'b0;
        w_rx_done    = 1'b0;
        w_frame_err  = 1'b0;
        case (r_rx_state)
            RX_IDLE: begin
                w_rx_cnt_clr = 1'b1;
                if (!r_rx_sync) w_rx_next = RX_START;
            end
            RX_START: if (w_rx_half) begin
                w_rx_cnt_clr = 1'b1;
                w_rx_next    = r_rx_sync ? RX_IDLE : RX_DATA;
            end
            RX_DATA: if (w_rx_tick) begin
                w_rx_cnt_clr = 1'b1;
                if (r_rx_idx == IDX_W'(DATA_W - 1)) w_rx_next = RX_STOP;
            end
            RX_STOP: if (w_rx_tick) begin
                w_rx_cnt_clr = 1'b1;
                if (r_rx_sync) begin
                    w_rx_done = 1'b1;
                    w_rx_next = RX_IDLE;
                end else begin
                    w_frame_err = 1'b1;
                    w_rx_next   = RX_WAIT_HIGH;
                end
            end
            RX_WAIT_HIGH: begin
                w_rx_cnt_clr = 1'b1;
                if (r_rx_sync) w_rx_next = RX_IDLE;
            end
            default: w_rx_next = RX_IDLE;
        endcase
    end

    // A new error outranks clearErr arriving in the same cycle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_rx_state  <= RX_IDLE;
            r_rx_meta   <= 1'b1;
            r_rx_sync   <= 1'b1;
            r_rx_cnt    <= '0;
            r_rx_idx    <= '0;
            r_rx_shift  <= '0;
            r_rx_push   <= 1'b0;
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_rx_state <= w_rx_next;
            r_rx_meta  <= RX;
            r_rx_sync  <= r_rx_meta;
            r_rx_cnt   <= w_rx_cnt_clr ? '0 : r_rx_cnt + 1'b1;
            if (r_rx_state == RX_START) begin
                r_rx_idx <= '0;
            end else if (r_rx_state == RX_DATA && w_rx_tick) begin
                r_rx_shift <= {r_rx_sync, r_rx_shift[DATA_W-1:1]};
                r_rx_idx   <= r_rx_idx + 1'b1;
            end
            r_rx_push   <= w_rx_done;
            r_overrun   <= (r_rx_push && w_rx_full) || (r_overrun && !clearErr);
            r_frame_err <= w_frame_err || (r_frame_err && !clearErr);
        end
    end

    always_comb begin
        status                   = '0;
        status[c_STAT_TX_FULL]   = w_tx_full;
        status[c_STAT_TX_EMPTY]  = w_tx_empty;
        status[c_STAT_RX_FULL]   = w_rx_full;
        status[c_STAT_RX_EMPTY]  = w_rx_empty;
        status[c_STAT_OVERRUN]   = r_overrun;
        status[c_STAT_FRAME_ERR] = r_frame_err;
        status[c_STAT_TX_BUSY]   = (r_tx_state != TX_IDLE);
        status[c_STAT_LEVEL_LSB +: 8] = 8'(w_rx_level);
    end

    assign dataOut = w_rx_empty ? '0 : w_rx_head;
    assign TX      = r_tx;

endmodule

`default_nettype wire
